// File: rtl/rx_sample_buffer_if.sv
// rx_sample_buffer_if: sample-in / CPU-drain / overrun-status bundle.
// master = host side (drives strobes), slave = buffer side.
interface rx_sample_buffer_if;
  logic        smp_stb;
  logic [15:0] smp_data;
  logic        rd_start;
  logic        rx_rd;
  logic        hb_orst;
  logic [15:0] rx_dout;
  logic        rx_avail;
  logic        rx_busy;
  logic        hb_ovfl;

  modport master (
    output smp_stb, smp_data, rd_start, rx_rd, hb_orst,
    input  rx_dout, rx_avail, rx_busy, hb_ovfl
  );

  modport slave (
    input  smp_stb, smp_data, rd_start, rx_rd, hb_orst,
    output rx_dout, rx_avail, rx_busy, hb_ovfl
  );
endinterface

// File: rtl/rx_sample_buffer.sv
// rx_sample_buffer: ping-pong DDC sample buffer feeding the host SPI bridge.
// Ports: hb_clk, hb_rst_n (async low), bus (slave): smp_stb/smp_data in,
//   rd_start/rx_rd in, rx_dout/rx_avail/rx_busy out, hb_ovfl out, hb_orst in.
// Option: RX_BUF_TSTAMP_EN prefixes each drained bank with a sequence header.
module rx_sample_buffer #(
  parameter int NWORDS = 512
) (
  input  logic         hb_clk,
  input  logic         hb_rst_n,
  rx_sample_buffer_if.slave bus
);

  localparam int AW = $clog2(NWORDS);
  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREF,
    S_READ
  } state_t;

  state_t        state;
  logic          wr_bank;
  logic          rd_bank;
  logic          pending;
  logic          ovfl;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [15:0]   mem [2*NWORDS];
  logic [15:0]   mem_q;

  logic bank_done;
  logic rd_take;
  logic rd_last;
  logic rel;
  logic swap;
  logic ovr;

`ifdef RX_BUF_TSTAMP_EN
  logic [15:0] bank_seq;
  logic        hdr_ph;
`endif

  always_comb begin
    bank_done  = bus.smp_stb && (wr_ptr == LAST);
    rd_take    = (state == S_READ) && bus.rx_rd;
    rd_ptr_nxt = rd_ptr;
`ifdef RX_BUF_TSTAMP_EN
    rd_last = !hdr_ph && (rd_ptr == LAST);
    if (rd_take && !hdr_ph) rd_ptr_nxt = rd_ptr + 1'b1;
`else
    rd_last = (rd_ptr == LAST);
    if (rd_take) rd_ptr_nxt = rd_ptr + 1'b1;
`endif
    rel  = rd_take && rd_last;
    // A release in the same cycle frees the bank for the swap.
    swap = bank_done && (!pending || rel);
    ovr  = bank_done && !swap;
  end

  // Read address looks ahead so the next word lands on rx_dout
  // the cycle after rx_rd.
  always_ff @(posedge hb_clk) begin
    if (bus.smp_stb) mem[{wr_bank, wr_ptr}] <= bus.smp_data;
    mem_q <= mem[{rd_bank, rd_ptr_nxt}];
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      state    <= S_IDLE;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      pending  <= 1'b0;
      ovfl     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
`ifdef RX_BUF_TSTAMP_EN
      bank_seq <= '0;
      hdr_ph   <= 1'b0;
`endif
    end else begin
      if (bus.smp_stb) wr_ptr <= wr_ptr + 1'b1;

      if (swap) begin
        wr_bank  <= ~wr_bank;
        rd_bank  <= wr_bank;
`ifdef RX_BUF_TSTAMP_EN
        bank_seq <= bank_seq + 16'd1;
`endif
      end

      if (swap)     pending <= 1'b1;
      else if (rel) pending <= 1'b0;

      // Overrun set beats a coincident clear.
      if (ovr)              ovfl <= 1'b1;
      else if (bus.hb_orst) ovfl <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (bus.rd_start && pending) begin
            state  <= S_PREF;
            rd_ptr <= '0;
          end
        end
        S_PREF: begin
          state <= S_READ;
`ifdef RX_BUF_TSTAMP_EN
          hdr_ph <= 1'b1;
`endif
        end
        S_READ: begin
          rd_ptr <= rd_ptr_nxt;
`ifdef RX_BUF_TSTAMP_EN
          if (rd_take) hdr_ph <= 1'b0;
`endif
          if (rel) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RX_BUF_TSTAMP_EN
  assign bus.rx_dout = (state != S_READ) ? 16'h0000 :
                       hdr_ph ? bank_seq : mem_q;
`else
  assign bus.rx_dout = (state == S_READ) ? mem_q : 16'h0000;
`endif
  assign bus.rx_avail = pending;
  assign bus.rx_busy  = (state != S_IDLE);
  assign bus.hb_ovfl  = ovfl;

endmodule

// File: tb/tb_rx_sample_buffer.sv
// tb_rx_sample_buffer: randomized + directed bench for rx_sample_buffer.
// Queue-based bank model feeds a scoreboard checked by a negedge monitor.
module tb_rx_sample_buffer;

  localparam int N = 16;
`ifdef RX_BUF_TSTAMP_EN
  localparam int TS = 1;
`else
  localparam int TS = 0;
`endif

  logic hb_clk = 1'b0;
  logic hb_rst_n = 1'b1;

  rx_sample_buffer_if bus();

  rx_sample_buffer #(.NWORDS(N)) dut (
    .hb_clk   (hb_clk),
    .hb_rst_n (hb_rst_n),
    .bus      (bus)
  );

  always #5 hb_clk = ~hb_clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_wr[$];
  logic [15:0] m_pend_data[$];
  bit          m_pend, m_ovfl, m_lat, m_reading;
  int          m_left;
  logic [15:0] m_seq;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wr.delete();
    m_pend_data.delete();
    m_pend = 0;
    m_ovfl = 0;
    m_lat = 0;
    m_reading = 0;
    m_left = 0;
    m_seq = 16'h0;
  endtask

  // Advance one clock and apply the bank rules to the sampled inputs.
  task automatic tick();
    bit cons, acc;
    @(posedge hb_clk);
    cons = m_reading && bus.rx_rd;
    acc  = bus.rd_start && m_pend && !m_lat && !m_reading;
    if (cons) begin
      m_left--;
      if (m_left == 0) begin
        m_reading = 0;
        m_pend = 0;
      end
    end
    if (m_lat) begin
      m_lat = 0;
      m_reading = 1;
    end
    if (acc) begin
      m_lat = 1;
      m_left = N + TS;
      if (TS != 0) exp_q.push_back(m_seq);
      foreach (m_pend_data[i]) exp_q.push_back(m_pend_data[i]);
    end
    if (bus.hb_orst) m_ovfl = 0;
    if (bus.smp_stb) begin
      m_wr.push_back(bus.smp_data);
      if (m_wr.size() == N) begin
        if (!m_pend) begin
          m_pend_data = m_wr;
          m_pend = 1;
          m_seq++;
        end else begin
          m_ovfl = 1;
        end
        m_wr.delete();
      end
    end
    #1;
  endtask

  task automatic step(bit stb, logic [15:0] d, bit start, bit rd, bit orst);
    bus.smp_stb  = stb;
    bus.smp_data = d;
    bus.rd_start = start;
    bus.rx_rd    = rd;
    bus.hb_orst  = orst;
    tick();
  endtask

  task automatic idle();
    step(0, 16'h0, 0, 0, 0);
  endtask

  task automatic fill(int n);
    for (int i = 0; i < n; i++) step(1, 16'($urandom), 0, 0, 0);
  endtask

  task automatic drain(bit b2b);
    int c;
    step(0, 16'h0, 1, 0, 0);
    for (c = 0; c < 200; c++) begin
      if (!m_lat && !m_reading) break;
      step(0, 16'h0, 0, m_reading && (b2b || $urandom_range(1) == 1), 0);
    end
    if (c == 200) check("drain_timeout", 1, 0);
  endtask

  // Scoreboard monitor: flags and rx_dout vs. model each cycle.
  initial begin
    forever begin
      @(negedge hb_clk);
      if (hb_rst_n) begin
        check("avail", bus.rx_avail, m_pend);
        check("ovfl", bus.hb_ovfl, m_ovfl);
        check("busy", bus.rx_busy, m_lat || m_reading);
        if (m_reading) begin
          if (exp_q.size() == 0) begin
            check("dout_underflow", 1, 0);
          end else begin
            check("dout", bus.rx_dout, exp_q[0]);
            if (bus.rx_rd) void'(exp_q.pop_front());
          end
        end else begin
          check("dout_zero", bus.rx_dout, 16'h0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.smp_stb = 0;
    bus.smp_data = 0;
    bus.rd_start = 0;
    bus.rx_rd = 0;
    bus.hb_orst = 0;
    model_reset();
    #2 hb_rst_n = 1'b0;
    #1;
    check("rst_dout", bus.rx_dout, 16'h0);
    check("rst_avail", bus.rx_avail, 0);
    check("rst_busy", bus.rx_busy, 0);
    check("rst_ovfl", bus.hb_ovfl, 0);
    #20 hb_rst_n = 1'b1;

    // 1: ordered bank, back-to-back drain
    for (int i = 0; i < N; i++) step(1, 16'h1000 + 16'(i), 0, 0, 0);
    check("t1_avail", bus.rx_avail, 1);
    drain(1);
    idle();
    check("t1_avail_after", bus.rx_avail, 0);
    check("t1_ovfl_after", bus.hb_ovfl, 0);

    // 2: overrun keeps first bank; set beats clear
    fill(N);
    fill(N);
    check("t2_ovfl_set", bus.hb_ovfl, 1);
    step(0, 16'h0, 0, 0, 1);
    check("t2_ovfl_clr", bus.hb_ovfl, 0);
    fill(N - 1);
    step(1, 16'($urandom), 0, 0, 1);
    check("t2_set_wins", bus.hb_ovfl, 1);
    drain(0);
    step(0, 16'h0, 0, 0, 1);
    check("t2_orst", bus.hb_ovfl, 0);

    // 3: release and bank-complete in the same cycle
    fill(N);
    step(0, 16'h0, 1, 0, 0);
    for (c = 0; c < 100; c++) begin
      if (m_reading && m_left == 1 && m_wr.size() == N - 1) begin
        step(1, 16'($urandom), 0, 1, 0);
        break;
      end
      step(m_wr.size() < N - 1, 16'($urandom), 0,
           m_reading && m_left > 1, 0);
    end
    if (c == 100) check("t3_timeout", 1, 0);
    check("t3_ovfl", bus.hb_ovfl, 0);
    check("t3_avail", bus.rx_avail, 1);
    drain(0);

    // 4: stray rx_rd / rd_start with nothing pending
    step(0, 16'h0, 1, 1, 0);
    step(0, 16'h0, 0, 1, 0);
    check("t4_busy", bus.rx_busy, 0);
    check("t4_dout", bus.rx_dout, 16'h0);
    fill(N);
    drain(1);

    // 5: async reset mid-drain with overrun flag set
    fill(N);
    fill(N);
    step(0, 16'h0, 1, 0, 0);
    idle();
    for (int i = 0; i < 7; i++) step(0, 16'h0, 0, 1, 0);
    bus.rx_rd = 0;
    #2 hb_rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_dout", bus.rx_dout, 16'h0);
    check("t5_avail", bus.rx_avail, 0);
    check("t5_busy", bus.rx_busy, 0);
    check("t5_ovfl", bus.hb_ovfl, 0);
    repeat (2) @(posedge hb_clk);
    #2 hb_rst_n = 1'b1;
    fill(N);
    drain(1);
    fill(N);
    drain(0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(2) != 0, 16'($urandom),
           $urandom_range(7) == 0,
           m_reading ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0),
           $urandom_range(63) == 0);
    end
    for (c = 0; c < 200; c++) begin
      if (!m_lat && !m_reading) break;
      step(0, 16'h0, 0, m_reading, 0);
    end
    if (c == 200) check("final_timeout", 1, 0);
    idle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
